// File: rtl/fpu_seq_ctrl.sv
// Sequencer between an issue port and a multi-cycle FPU datapath: captures operands, times latency, holds result.
// Optional sticky overflow/illegal flags are built only when FPU_SEQ_FLAGS_EN is defined.
module fpu_seq_ctrl #(
  parameter int unsigned LAT_ADD  = 2,
  parameter int unsigned LAT_MUL  = 3,
  parameter int unsigned LAT_DIV  = 8,
  parameter int unsigned LAT_SQRT = 8,
  parameter int unsigned LAT_MISC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_func5,
  input  logic        req_rs2_f1,
  input  logic [2:0]  req_rm,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_overflow,
  output logic        rsp_illegal,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [4:0]  fpu_func5,
  output logic        fpu_rs2_f1,
  output logic [2:0]  fpu_rm,
  input  logic [31:0] fpu_result,
  input  logic        fpu_overflow,
  output logic        busy,
  input  logic        flag_clr,
  output logic        flag_of_sticky,
  output logic        flag_nv_sticky
);

  // A configured latency of 0 behaves as a single-cycle op.
  localparam int unsigned EFF_ADD  = (LAT_ADD  == 0) ? 1 : LAT_ADD;
  localparam int unsigned EFF_MUL  = (LAT_MUL  == 0) ? 1 : LAT_MUL;
  localparam int unsigned EFF_DIV  = (LAT_DIV  == 0) ? 1 : LAT_DIV;
  localparam int unsigned EFF_SQRT = (LAT_SQRT == 0) ? 1 : LAT_SQRT;
  localparam int unsigned EFF_MISC = (LAT_MISC == 0) ? 1 : LAT_MISC;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       op_illegal;

  function automatic logic is_legal(input logic [4:0] f);
    case (f)
      5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
      5'b01011, 5'b10100, 5'b11000, 5'b11010, 5'b11100, 5'b11110: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lat_m1(input logic [4:0] f);
    case (f)
      5'b00000, 5'b00001: lat_m1 = 4'(EFF_ADD - 1);
      5'b00010:           lat_m1 = 4'(EFF_MUL - 1);
      5'b00011:           lat_m1 = 4'(EFF_DIV - 1);
      5'b01011:           lat_m1 = 4'(EFF_SQRT - 1);
      default:            lat_m1 = 4'(EFF_MISC - 1);
    endcase
  endfunction

  // Capture happens on the last EXEC cycle; shared by the response and flag logic.
  logic capture;
  assign capture = (state == EXEC) && (cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      op_illegal   <= 1'b0;
      req_ready    <= 1'b1;
      busy         <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_result   <= 32'd0;
      rsp_overflow <= 1'b0;
      rsp_illegal  <= 1'b0;
      fpu_a        <= 32'd0;
      fpu_b        <= 32'd0;
      fpu_func5    <= 5'd0;
      fpu_rs2_f1   <= 1'b0;
      fpu_rm       <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            state      <= EXEC;
            req_ready  <= 1'b0;
            busy       <= 1'b1;
            fpu_a      <= req_a;
            fpu_b      <= req_b;
            fpu_func5  <= req_func5;
            fpu_rs2_f1 <= req_rs2_f1;
            fpu_rm     <= req_rm;
            cnt        <= lat_m1(req_func5);
            op_illegal <= !is_legal(req_func5);
          end
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            state        <= DONE;
            rsp_valid    <= 1'b1;
            rsp_result   <= op_illegal ? 32'd0 : fpu_result;
            rsp_overflow <= op_illegal ? 1'b0 : fpu_overflow;
            rsp_illegal  <= op_illegal;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef FPU_SEQ_FLAGS_EN
  // Per-flag priority: a set in the clear cycle wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_of_sticky <= 1'b0;
      flag_nv_sticky <= 1'b0;
    end else begin
      if (capture && !op_illegal && fpu_overflow) flag_of_sticky <= 1'b1;
      else if (flag_clr)                          flag_of_sticky <= 1'b0;
      if (capture && op_illegal)                  flag_nv_sticky <= 1'b1;
      else if (flag_clr)                          flag_nv_sticky <= 1'b0;
    end
  end
`else
  logic unused_flag_in;
  assign unused_flag_in = flag_clr ^ capture;
  assign flag_of_sticky = 1'b0;
  assign flag_nv_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// Directed + randomized bench for fpu_seq_ctrl against a transaction-level latency/result model.
module tb_fpu_seq_ctrl;

  logic        clk, rst;
  logic        req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic [4:0]  req_func5;
  logic        req_rs2_f1;
  logic [2:0]  req_rm;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_overflow, rsp_illegal;
  logic [31:0] fpu_a, fpu_b;
  logic [4:0]  fpu_func5;
  logic        fpu_rs2_f1;
  logic [2:0]  fpu_rm;
  logic [31:0] fpu_result;
  logic        fpu_overflow;
  logic        busy;
  logic        flag_clr, flag_of_sticky, flag_nv_sticky;

`ifdef FPU_SEQ_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  localparam logic [4:0] LEGAL [12] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
                                        5'b01011, 5'b10100, 5'b11000, 5'b11010, 5'b11100, 5'b11110};

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  bit of_m = 1'b0;
  bit nv_m = 1'b0;

  fpu_seq_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_func5(req_func5), .req_rs2_f1(req_rs2_f1), .req_rm(req_rm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .rsp_illegal(rsp_illegal),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_func5(fpu_func5), .fpu_rs2_f1(fpu_rs2_f1), .fpu_rm(fpu_rm),
    .fpu_result(fpu_result), .fpu_overflow(fpu_overflow), .busy(busy),
    .flag_clr(flag_clr), .flag_of_sticky(flag_of_sticky), .flag_nv_sticky(flag_nv_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_legal(input logic [4:0] f);
    foreach (LEGAL[i]) if (LEGAL[i] == f) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int ref_lat(input logic [4:0] f);
    int l;
    if (f == 5'b00000 || f == 5'b00001) l = 2;
    else if (f == 5'b00010)             l = 3;
    else if (f == 5'b00011 || f == 5'b01011) l = 8;
    else                                l = 1;
    return (l < 1) ? 1 : l;
  endfunction

  task automatic scramble_req();
    req_valid  = 1'($urandom);
    req_a      = $urandom;
    req_b      = $urandom;
    req_func5  = 5'($urandom);
    req_rs2_f1 = 1'($urandom);
    req_rm     = 3'($urandom);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_of"}, flag_of_sticky, of_m);
    check({tag, "_nv"}, flag_nv_sticky, nv_m);
  endtask

  // One complete transaction: accept, EXEC timing, capture, backpressured hold, handshake.
  task automatic run_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic rs2, input logic [2:0] rm, input int bp,
                        input bit race, input bit clr_after,
                        input bit use_fixed, input logic [31:0] fixed_res);
    int lat;
    bit ill;
    logic [31:0] exp_res;
    logic exp_ov;
    lat = ref_lat(f);
    ill = !ref_legal(f);
    exp_res = 32'd0;
    exp_ov = 1'b0;
    check("idle_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_a = a; req_b = b; req_func5 = f; req_rs2_f1 = rs2; req_rm = rm;
    flag_clr = 1'b0;
    last_acc = cyc;
    tick();
    for (int k = 1; k <= lat; k++) begin
      check("exec_fpu_a", fpu_a, a);
      check("exec_fpu_b", fpu_b, b);
      check("exec_fpu_ctl", {fpu_func5, fpu_rs2_f1, fpu_rm}, {f, rs2, rm});
      check("exec_busy", busy, 1'b1);
      check("exec_ready", req_ready, 1'b0);
      check("exec_rsp_valid", rsp_valid, 1'b0);
      scramble_req();
      fpu_result   = use_fixed ? fixed_res : $urandom;
      fpu_overflow = race ? 1'b1 : 1'($urandom);
      rsp_ready    = 1'($urandom);
      flag_clr     = race && (k == lat);
      if (k == lat) begin
        exp_res = ill ? 32'd0 : fpu_result;
        exp_ov  = ill ? 1'b0 : fpu_overflow;
        if (FLAGS) begin
          of_m = exp_ov ? 1'b1 : (flag_clr ? 1'b0 : of_m);
          nv_m = ill    ? 1'b1 : (flag_clr ? 1'b0 : nv_m);
        end
      end
      tick();
    end
    flag_clr = 1'b0;
    for (int j = 0; j <= bp; j++) begin
      check("done_rsp_valid", rsp_valid, 1'b1);
      check("done_result", rsp_result, exp_res);
      check("done_overflow", rsp_overflow, exp_ov);
      check("done_illegal", rsp_illegal, ill);
      check("done_ready", req_ready, 1'b0);
      check("done_fpu_a", fpu_a, a);
      check_flags("done_flag");
      scramble_req();
      fpu_result   = $urandom;
      fpu_overflow = 1'($urandom);
      rsp_ready    = (j == bp);
      flag_clr     = (j == bp) && clr_after;
      if (FLAGS && flag_clr) begin
        of_m = 1'b0;
        nv_m = 1'b0;
      end
      tick();
    end
    rsp_ready = 1'b0;
    flag_clr  = 1'b0;
    req_valid = 1'b0;
    check("post_rsp_valid", rsp_valid, 1'b0);
    check("post_busy", busy, 1'b0);
    check("post_ready", req_ready, 1'b1);
    check_flags("post_flag");
  endtask

  initial begin
    int acc1;
    logic [4:0] f;
    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_func5 = '0; req_rs2_f1 = 1'b0;
    req_rm = '0; rsp_ready = 1'b0; fpu_result = '0; fpu_overflow = 1'b0; flag_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp", {rsp_result, rsp_overflow, rsp_illegal}, 34'd0);
    check("rst_fpu", {fpu_a ^ fpu_b, fpu_func5, fpu_rs2_f1, fpu_rm}, 41'd0);
    check("rst_fpu_a", fpu_a, 32'd0);
    check_flags("rst_flag");

    // add 1.0 + 2.0
    run_op(5'b00000, 32'h3F800000, 32'h40000000, 1'b0, 3'd0, 0, 1'b0, 1'b0, 1'b1, 32'h40400000);
    // divide with 5 cycles of backpressure
    run_op(5'b00011, $urandom, $urandom, 1'b1, 3'd3, 5, 1'b0, 1'b0, 1'b0, 32'd0);
    // illegal func5
    run_op(5'b01111, $urandom, $urandom, 1'b0, 3'd1, 1, 1'b0, 1'b0, 1'b0, 32'd0);
    // overflow at capture racing flag_clr, then clear alone
    run_op(5'b00010, $urandom, $urandom, 1'b0, 3'd2, 0, 1'b1, 1'b1, 1'b0, 32'd0);
    // back-to-back muls: spacing is LAT_MUL+2
    run_op(5'b00010, 32'h11111111, 32'h22222222, 1'b0, 3'd0, 0, 1'b0, 1'b0, 1'b0, 32'd0);
    acc1 = last_acc;
    run_op(5'b00010, 32'h33333333, 32'h44444444, 1'b1, 3'd7, 0, 1'b0, 1'b0, 1'b0, 32'd0);
    check("b2b_spacing", 32'(last_acc - acc1), 32'd5);
    // leave flags set before the mid-op reset
    run_op(5'b00001, $urandom, $urandom, 1'b0, 3'd0, 0, 1'b1, 1'b0, 1'b0, 32'd0);
    run_op(5'b10101, $urandom, $urandom, 1'b0, 3'd0, 0, 1'b0, 1'b0, 1'b0, 32'd0);

    // reset on the 4th EXEC cycle of a sqrt
    check("sqrt_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_a = 32'h40800000; req_b = $urandom; req_func5 = 5'b01011;
    req_rs2_f1 = 1'b1; req_rm = 3'd5;
    tick();
    req_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      check("sqrt_busy", busy, 1'b1);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    of_m = 1'b0;
    nv_m = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_rsp_valid", rsp_valid, 1'b0);
    check("abort_ready", req_ready, 1'b1);
    check("abort_fpu_a", fpu_a, 32'd0);
    check("abort_fpu_ctl", {fpu_b, fpu_func5, fpu_rs2_f1, fpu_rm}, 41'd0);
    check_flags("abort_flag");
    for (int k = 0; k < 10; k++) begin
      tick();
      check("abort_quiet", rsp_valid, 1'b0);
    end

    // randomized mix of legal and arbitrary func5
    for (int n = 0; n < 30; n++) begin
      f = ($urandom_range(0, 1) == 0) ? LEGAL[$urandom_range(0, 11)] : 5'($urandom);
      run_op(f, $urandom, $urandom, 1'($urandom), 3'($urandom), $urandom_range(0, 3),
             1'($urandom_range(0, 3) == 0), 1'($urandom), 1'b0, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_seq_ctrl.md
FPU_SEQ_CTRL -- requirements
Module: fpu_seq_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- LAT_ADD, 2, EXEC cycles for func5 00000/00001 (add/sub)
- LAT_MUL, 3, EXEC cycles for 00010 (mul)
- LAT_DIV, 8, EXEC cycles for 00011 (div)
- LAT_SQRT, 8, EXEC cycles for 01011 (sqrt)
- LAT_MISC, 1, EXEC cycles for all other legal func5

REQ-002 Ports, one per line (name, direction, width, meaning). The block has one clock; reset is synchronous and active-high.
- clk, in, 1, clock, rising edge
- rst, in, 1, synchronous active-high reset
- req_valid, in, 1, request present
- req_ready, out, 1, request accepted this cycle if also req_valid
- req_a, in, 32, operand A
- req_b, in, 32, operand B
- req_func5, in, 5, operation select
- req_rs2_f1, in, 1, signed/unsigned convert select
- req_rm, in, 3, rounding mode / sub-op
- rsp_valid, out, 1, result held
- rsp_ready, in, 1, consumer accepts result
- rsp_result, out, 32, captured result
- rsp_overflow, out, 1, captured overflow
- rsp_illegal, out, 1, func5 was not legal
- fpu_a, out, 32, registered operand A to the FPU datapath
- fpu_b, out, 32, registered operand B to the FPU datapath
- fpu_func5, out, 5, registered func5 to the FPU datapath
- fpu_rs2_f1, out, 1, registered convert select to the FPU datapath
- fpu_rm, out, 3, registered rounding mode to the FPU datapath
- fpu_result, in, 32, FPU datapath result
- fpu_overflow, in, 1, FPU datapath overflow
- busy, out, 1, state is not IDLE
- flag_clr, in, 1, clear the sticky flags
- flag_of_sticky, out, 1, sticky overflow
- flag_nv_sticky, out, 1, sticky illegal-op

Function
REQ-003 The FSM has three states, IDLE, EXEC and DONE, with these transitions:
- IDLE to EXEC on req_valid.
- EXEC to DONE when cnt==0.
- DONE to IDLE on rsp_ready.

REQ-004 req_ready SHALL be 1 only in IDLE; a request is accepted at an edge where req_ready && req_valid.

REQ-005 On accept, the block SHALL register req_a, req_b, req_func5, req_rs2_f1 and req_rm into the fpu_* outputs, which then stay stable until the next accept.

REQ-006 On accept, the 4-bit counter cnt SHALL load the latency for req_func5 minus 1; each EXEC cycle with cnt!=0 decrements it.

REQ-007 Legal func5 values are 00000, 00001, 00010, 00011, 00100, 00101, 01011, 10100, 11000, 11010, 11100 and 11110; any other value SHALL be illegal and use LAT_MISC.

REQ-008 At the edge leaving EXEC, the block SHALL capture rsp_result=fpu_result and rsp_overflow=fpu_overflow, or 0/0 with rsp_illegal=1 when the func5 was illegal.

REQ-009 rsp_valid SHALL be 1 exactly in DONE; the first rsp_valid cycle follows accept by LAT+1 edges (e.g. LAT_MUL=3 gives rsp_valid in the 4th cycle after the accept cycle).

REQ-010 rsp_result, rsp_overflow and rsp_illegal SHALL hold stable while rsp_valid && !rsp_ready.

REQ-011 A response handshake and a new accept SHALL never occur in the same cycle; the minimum request-to-request spacing is LAT+2 cycles.

REQ-012 req_valid in EXEC or DONE SHALL be ignored (not captured) until the FSM returns to IDLE.

REQ-013 A latency parameter of 0 SHALL be treated as 1; values above 15 are illegal configurations.

REQ-014 busy SHALL equal (state!=IDLE).

Reset
REQ-015 When rst is 1 at a clock edge, the block SHALL reset to:
- state IDLE, cnt 0
- rsp_result 0, rsp_overflow 0, rsp_illegal 0, rsp_valid 0
- all fpu_* outputs 0
- both sticky flags 0
- req_ready 1 in the first cycle after reset

REQ-016 rst asserted during EXEC or DONE SHALL abort the operation, discard the pending response and produce no rsp_valid.

Configuration
REQ-017 With FPU_SEQ_FLAGS_EN defined:
- flag_of_sticky sets on a capture with overflow=1; flag_nv_sticky sets on a capture with illegal=1.
- Both clear on flag_clr.
- When a set and flag_clr occur in the same cycle, the set wins.

REQ-018 Without FPU_SEQ_FLAGS_EN, flag_of_sticky and flag_nv_sticky SHALL be tied 0, flag_clr is ignored, and no flag registers are built.

Verification
REQ-019 Add: req_valid in IDLE with func5=00000, a=0x3F800000, b=0x40000000 -> fpu_* registered next cycle; rsp_valid after 3 edges with rsp_result=fpu_result=0x40400000.

REQ-020 Divide with backpressure: func5=00011, rsp_ready held 0 for 5 cycles -> rsp_valid rises 9 edges after accept; result held constant; req_ready=0 throughout; IDLE one edge after rsp_ready=1.

REQ-021 Illegal op: func5=01111 -> rsp_valid after 2 edges with rsp_result=0 and rsp_illegal=1; with FPU_SEQ_FLAGS_EN, flag_nv_sticky=1.

REQ-022 Reset mid-op: rst asserted on the 4th EXEC cycle of a sqrt -> next cycle IDLE, rsp_valid=0, req_ready=1, fpu_*=0, flags=0.

REQ-023 Flag race: fpu_overflow=1 at capture while flag_clr=1 in the same cycle -> flag_of_sticky=1; flag_clr alone the next cycle -> 0.

REQ-024 Back-to-back requests: req_valid held high with two different mul requests -> the second is accepted only after the first's rsp handshake, at exactly 5-cycle spacing; the second's operands are not captured early.
